// File: rtl/inst_encoder.sv
// RV32I field-bundle encoder with a single-register valid/ready output stage.
// Illegal bundles (unknown opcode, immediate out of range or misaligned) emit
// a NOP flagged with out_err and set a sticky error bit.
module inst_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic             err_sticky,
    input  logic             clr_err,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic             r_valid;
    logic [31:0]      r_inst;
    logic             r_err;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic        w_illegal;
    logic [31:0] w_word;

    // A signed value fits an N-bit field when bits [31:N-1] are all copies of the sign.
    assign w_fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign w_fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign w_fits21 = (&imm[31:20]) || !(|imm[31:20]);

    assign in_ready   = !r_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    assign out_valid  = r_valid;
    assign out_inst   = r_inst;
    assign out_err    = r_err;
    assign err_sticky = r_sticky;
    assign inst_count = r_count;

    // Decode the opcode, pack the fields of its format and flag illegal bundles.
    always_comb begin
        w_word    = NOP;
        w_illegal = 1'b0;
        case (op)
            OP_R: begin
                w_word = {funct7, rs2, rs1, funct3, rd, op};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                // Shift-immediates ride through imm[11:5] untouched.
                w_illegal = !w_fits12;
                w_word    = {imm[11:0], rs1, funct3, rd, op};
            end
            OP_STORE: begin
                w_illegal = !w_fits12;
                w_word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            end
            OP_BRANCH: begin
                w_illegal = !w_fits13 || imm[0];
                w_word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            end
            OP_LUI, OP_AUIPC: begin
                w_illegal = |imm[11:0];
                w_word    = {imm[31:12], rd, op};
            end
            OP_JAL: begin
                w_illegal = !w_fits21 || imm[0];
                w_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_word = NOP;
        end
    end

    // Output register: load on input transfer, drop on output transfer, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_inst  <= w_word;
            r_err   <= w_illegal;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky error: an accepted illegal bundle takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_in_fire && w_illegal) begin
            r_sticky <= 1'b1;
        end else if (clr_err) begin
            r_sticky <= 1'b0;
        end
    end

    // Count words handed downstream; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_fire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a reference model predicts each accepted
// bundle's word; the negedge monitor pops and compares on each output transfer.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        err_sticky;
    logic        clr_err;
    logic [15:0] inst_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_inst4;
    logic        out_err4;
    logic        err_sticky4;
    logic [3:0]  inst_count4;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_cnt  = 16'd0;
    bit          rnd_done;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .clr_err    (clr_err),
        .inst_count (inst_count)
    );

    inst_encoder #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_inst   (out_inst4),
        .out_err    (out_err4),
        .err_sticky (err_sticky4),
        .clr_err    (clr_err),
        .inst_count (inst_count4)
    );

    // Reference encoder using signed arithmetic range checks.
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [31:0] im);
        exp_t e;
        int   si;
        si     = $signed(im);
        e.err  = 1'b0;
        e.inst = 32'h0;
        case (o)
            7'b0110011: e.inst = {f7, s2, s1, f3, d, o};
            7'b1100111, 7'b0000011, 7'b0010011: begin
                e.err  = (si < -2048) || (si > 2047);
                e.inst = {im[11:0], s1, f3, d, o};
            end
            7'b0100011: begin
                e.err  = (si < -2048) || (si > 2047);
                e.inst = {im[11:5], s2, s1, f3, im[4:0], o};
            end
            7'b1100011: begin
                e.err  = (si < -4096) || (si > 4094) || im[0];
                e.inst = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], o};
            end
            7'b0110111, 7'b0010111: begin
                e.err  = (im[11:0] != 12'h0);
                e.inst = {im[31:12], d, o};
            end
            7'b1101111: begin
                e.err  = (si < -1048576) || (si > 1048574) || im[0];
                e.inst = {im[20], im[10:1], im[11], im[19:12], d, o};
            end
            default: e.err = 1'b1;
        endcase
        if (e.err) e.inst = 32'h00000013;
        return e;
    endfunction

    // Scoreboard: compare on output transfer, then push on input transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL sb_unexpected: got out_inst=%h with nothing expected", out_inst);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_inst !== e.inst || out_err !== e.err) begin
                        n_fails++;
                        $display("FAIL sb_word: got inst=%h err=%b, expected inst=%h err=%b",
                                 out_inst, out_err, e.inst, e.err);
                    end
                end
                exp_cnt++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op, funct3, funct7, rd, rs1, rs2, imm));
            end
        end
    end

    task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        bit acc;
        op = o; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fails++;
        $display("FAIL send_timeout: in_ready=%b, required 1 within 60 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; clr_err = 1'b0;
        op = 7'b0010011; funct3 = 3'd0; funct7 = 7'd0; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
        imm = 32'hFFFFFFFF;
        #2;
        n_checks += 6;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
        if (out_inst !== 32'h0) begin n_fails++; $display("FAIL rst_inst: got %h, expected 0", out_inst); end
        if (out_err !== 1'b0) begin n_fails++; $display("FAIL rst_err: got %b, expected 0", out_err); end
        if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL rst_sticky: got %b, expected 0", err_sticky); end
        if (inst_count !== 16'd0) begin n_fails++; $display("FAIL rst_count: got %0d, expected 0", inst_count); end
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
        idle(3);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_drop: got out_valid=%b, expected 0", out_valid); end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_after_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_after_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fails++; $display("FAIL addi_valid: got %b, expected 1", out_valid); end
        if (out_inst !== 32'hFFF00093) begin n_fails++; $display("FAIL addi_inst: got %h, expected fff00093", out_inst); end
        if (out_err !== 1'b0) begin n_fails++; $display("FAIL addi_err: got %b, expected 0", out_err); end
        idle(1);
        n_checks++;
        if (inst_count !== 16'd1) begin n_fails++; $display("FAIL addi_count: got %0d, expected 1", inst_count); end
    endtask

    task automatic test_formats;
        out_ready = 1'b1;
        send(7'b1100011, 3'd0, 7'h55, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC);
        n_checks++;
        if (out_inst !== 32'hFE208EE3) begin n_fails++; $display("FAIL beq_inst: got %h, expected fe208ee3", out_inst); end
        send(7'b1101111, 3'd5, 7'h7F, 5'd1, 5'd7, 5'd8, 32'd2048);
        n_checks++;
        if (out_inst !== 32'h001000EF) begin n_fails++; $display("FAIL jal_inst: got %h, expected 001000ef", out_inst); end
        send(7'b0110111, 3'd3, 7'h11, 5'd5, 5'd3, 5'd4, 32'h12345000);
        n_checks++;
        if (out_inst !== 32'h123452B7) begin n_fails++; $display("FAIL lui_inst: got %h, expected 123452b7", out_inst); end
        send(7'b0100011, 3'd2, 7'h22, 5'd17, 5'd3, 5'd2, 32'd8);
        n_checks += 2;
        if (out_inst !== 32'h0021A423) begin n_fails++; $display("FAIL sw_inst: got %h, expected 0021a423", out_inst); end
        if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL legal_sticky: got %b, expected 0", err_sticky); end
        send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        n_checks += 3;
        if (out_inst !== 32'h00000013) begin n_fails++; $display("FAIL beq_bad_inst: got %h, expected 00000013", out_inst); end
        if (out_err !== 1'b1) begin n_fails++; $display("FAIL beq_bad_err: got %b, expected 1", out_err); end
        if (err_sticky !== 1'b1) begin n_fails++; $display("FAIL beq_bad_sticky: got %b, expected 1", err_sticky); end
        idle(2);
    endtask

    task automatic test_boundaries;
        logic [6:0]  ops [16];
        logic [31:0] imms[16];
        ops  = '{7'b0010011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b0100011,
                 7'b1100011, 7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111, 7'b1101111,
                 7'b0010111, 7'b0010111, 7'b1111111, 7'b0110011};
        imms = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd2047, 32'hFFFFF7FF,
                 32'd4094, 32'hFFFFF000, 32'd4096, 32'd1048574, 32'd1048576, 32'hFFF00000,
                 32'hABCDE000, 32'hABCDE800, 32'd0, 32'hDEADBEEF};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(ops[i], 3'(i), 7'(i * 5), 5'(i + 3), 5'(i * 2), 5'(31 - i), imms[i]);
        end
        idle(3);
    endtask

    task automatic test_random;
        logic [6:0] oplist[11];
        oplist = '{7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                   7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000, 7'b1110011};
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [6:0]  o;
                    logic [31:0] r;
                    logic [31:0] im;
                    o = oplist[$urandom_range(0, 10)];
                    r = $urandom;
                    case ($urandom_range(0, 3))
                        0: im = r;
                        1: im = {{20{r[11]}}, r[11:0]};
                        2: im = {{19{r[12]}}, r[12:1], 1'b0};
                        default: im = {{11{r[20]}}, r[20:1], 1'b0};
                    endcase
                    if ($urandom_range(0, 1) == 1) im[11:0] = (o[2]) ? 12'h0 : im[11:0];
                    send(o, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), im);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(3);
        n_checks++;
        if (inst_count !== exp_cnt) begin n_fails++; $display("FAIL rand_count: got %0d, expected %0d", inst_count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] base;
        out_ready = 1'b1;
        idle(2);
        base = inst_count;
        out_ready = 1'b0;
        send(7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        op = 7'b0010011; funct3 = 3'd1; rd = 5'd4; rs1 = 5'd4; imm = 32'd5;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks += 2;
            if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
            if (out_inst !== 32'h402081B3 || out_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL bp_hold: got valid=%b inst=%h, expected 1 402081b3", out_valid, out_inst);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(7'b0010011, 3'd1, 7'd0, 5'd4, 5'd4, 5'd0, 32'd5);
        send(7'b0000011, 3'd2, 7'd0, 5'd6, 5'd2, 5'd0, 32'hFFFFFFF0);
        idle(3);
        n_checks += 2;
        if (inst_count !== base + 16'd3) begin
            n_fails++;
            $display("FAIL bp_count: got %0d, expected %0d", inst_count, base + 16'd3);
        end
        if (sb.size() != 0) begin n_fails++; $display("FAIL bp_drain: got %0d queued, expected 0", sb.size()); end
    endtask

    task automatic test_sticky;
        out_ready = 1'b1;
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL clr_sticky: got %b, expected 0", err_sticky); end
        clr_err = 1'b1;
        send(7'b1111011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        clr_err = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b1) begin n_fails++; $display("FAIL set_wins: got %b, expected 1", err_sticky); end
        clr_err = 1'b1;
        send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        clr_err = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL clr_legal: got %b, expected 0", err_sticky); end
        idle(2);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(7'b0110011, 3'd7, 7'd0, 5'd2, 5'd3, 5'd4, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL mid_valid: got %b, expected 0", out_valid); end
        if (inst_count !== 16'd0) begin n_fails++; $display("FAIL mid_count: got %0d, expected 0", inst_count); end
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL mid_ready: got %b, expected 1", in_ready); end
        sb.delete();
        exp_cnt = 16'd0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(7'b0110111, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i) << 12);
        end
        idle(2);
        n_checks += 2;
        if (inst_count !== 16'd17) begin n_fails++; $display("FAIL wrap_count16: got %0d, expected 17", inst_count); end
        if (inst_count4 !== 4'd1) begin n_fails++; $display("FAIL wrap_count4: got %0d, expected 1", inst_count4); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
